crc32_rx_check_ctrl: RTL
========================

// Module: crc32_rx_check_ctrl
// PURPOSE
//  Sequences a byte-wide CRC32 engine (CRC32_D8) for the receive path, one frame at a time.
//  At start of frame it loads the engine seed, then feeds one registered byte per valid beat.
//  After the last byte it compares the engine result with the good-frame residue.
//  It reports a one-cycle status pulse and gates RX_READY, so LOAD and START never collide.
// PARAMETERS
//  CRC_SEED     32'hFFFF_FFFF  value driven on CRC_INIT at start of frame
//  CRC_RESIDUE  32'hC704_DD7B  engine value after a frame with correct FCS (FCS included, no final invert)
//  REFLECT_IN   1              1: CRC_DATA = bit-reversed RX_DATA (RX_DATA[0] -> CRC_DATA[7]); 0: straight
//  MIN_LEN      64             minimum frame length in bytes, FCS included
// PORTS
//  CLK          in   1   clock
//  RESET_N      in   1   asynchronous reset, active low
//  RX_DATA      in   8   frame byte
//  RX_VALID     in   1   RX_DATA valid; a byte is taken only when RX_VALID & RX_READY
//  RX_SOF       in   1   qualifies first byte of frame
//  RX_EOF       in   1   qualifies last byte of frame (last FCS byte)
//  RX_READY     out  1   controller accepts bytes
//  CRC_LOAD     out  1   to engine LOAD (combinational)
//  CRC_INIT     out  32  to engine CRC_IN, constant CRC_SEED
//  CRC_START    out  1   to engine START (registered)
//  CRC_DATA     out  8   to engine DATA_IN (registered)
//  CRC_VAL      in   32  from engine CRC_OUT
//  FRAME_DONE   out  1   one-cycle pulse: status fields below are valid
//  FRAME_GOOD   out  1   residue match & no LEN_ERR & no ABORT
//  FRAME_CRC_ERR out 1   residue mismatch
//  FRAME_LEN_ERR out 1   FRAME_LEN < MIN_LEN
//  FRAME_ABORT  out  1   frame ended by new SOF before EOF
//  FRAME_LEN    out  16  accepted byte count, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: state IDLE; RX_READY=1; CRC_START=0; CRC_DATA=0; FRAME_* and FRAME_LEN=0.
//  CRC_LOAD follows RX_READY. Reset mid-frame discards the frame without a FRAME_DONE.
//  States:
//   IDLE: RX_READY=1. CRC_LOAD = RX_VALID & RX_SOF. A non-SOF byte is ignored.
//         On an SOF byte: latch the byte, set count=1, go to RUN (or to FLUSH if RX_EOF is also set).
//   RUN:  RX_READY=1, no LOAD. Each accepted byte is latched and count increments.
//         CRC_START is high the cycle after each accepted byte, with CRC_DATA = that byte (latency 1).
//         An EOF byte is latched and the state goes to FLUSH.
//         An SOF byte (with or without EOF) sets abort and goes to FLUSH. The SOF byte is dropped,
//         not counted, not fed to the engine, and its frame is lost.
//   FLUSH: RX_READY=0. CRC_START is high this cycle only if the last byte was accepted (not aborted).
//          Go to CHECK.
//   CHECK: RX_READY=0. CRC_VAL now holds the final value. Compare with CRC_RESIDUE and register the flags.
//          Go to REPORT.
//   REPORT: FRAME_DONE=1 for one cycle, flags and FRAME_LEN valid, RX_READY=1, LOAD allowed.
//           On SOF: act as IDLE (next frame may start); otherwise go to IDLE.
//  Timing: EOF accepted in cycle e -> START in e+1 -> FRAME_DONE in e+3. Minimum gap EOF->SOF is 2 idle cycles.
//  Flags hold until the next FRAME_DONE; FRAME_DONE itself lasts one cycle.
//  On ABORT: FRAME_CRC_ERR=0, FRAME_GOOD=0, FRAME_LEN_ERR evaluated on count.
//  Count is 16-bit and saturates at 16'hFFFF (no wrap).
//  RX_VALID while RX_READY=0: the byte is dropped and does not change state.
// TESTING
//  1. MIN_LEN=1, SOF "123456789" then 26 39 F4 CB (EOF) -> FRAME_DONE at EOF+3, GOOD=1, LEN=13, CRC_VAL=C704DD7B.
//  2. Same frame, byte 5 XOR 8'h01 -> CRC_ERR=1, GOOD=0, LEN=13.
//  3. MIN_LEN=64, valid 60-byte frame -> LEN_ERR=1, GOOD=0; single SOF&EOF byte -> LEN=1, LEN_ERR=1.
//  4. SOF, 10 bytes, new SOF -> ABORT=1, LEN=10, CRC_ERR=0; following bytes ignored until next SOF.
//  5. Back-to-back frames, SOF driven on the REPORT cycle -> LOAD is never coincident with START; both frames GOOD.
//  6. RESET_N low mid-frame -> outputs at reset values at once; no FRAME_DONE; next frame checks GOOD.

Source files
------------

// File: rtl/crc32_rx_check_ctrl.sv
// Receive-side sequencer for a byte-wide CRC32 engine.
// Loads the engine seed on start of frame and feeds each accepted byte one
// cycle later. After the last byte it compares the engine value with the
// good-frame residue and pulses a status report. rx_ready_o is dropped
// while the final byte drains through the engine, so the seed load of the
// next frame can never coincide with a data strobe.
module crc32_rx_check_ctrl #(
  parameter logic [31:0] CRC_SEED    = 32'hFFFF_FFFF,
  parameter logic [31:0] CRC_RESIDUE = 32'hC704_DD7B,
  parameter bit          REFLECT_IN  = 1'b1,
  parameter int unsigned MIN_LEN     = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        rx_sof_i,
  input  logic        rx_eof_i,
  output logic        rx_ready_o,
  output logic        crc_load_o,
  output logic [31:0] crc_init_o,
  output logic        crc_start_o,
  output logic [7:0]  crc_data_o,
  input  logic [31:0] crc_val_i,
  output logic        frame_done_o,
  output logic        frame_good_o,
  output logic        frame_crc_err_o,
  output logic        frame_len_err_o,
  output logic        frame_abort_o,
  output logic [15:0] frame_len_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_CHECK,
    ST_REPORT
  } state_e;

  // Minimum length widened by one bit so a 16-bit count compares cleanly.
  localparam logic [16:0] MIN_LEN_W = 17'(MIN_LEN);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        abort_q, abort_d;
  logic        start_q, start_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        good_q, good_d;
  logic        crc_err_q, crc_err_d;
  logic        len_err_q, len_err_d;
  logic        abort_flag_q, abort_flag_d;
  logic [15:0] len_q, len_d;

  logic [7:0]  rx_data_rev;
  logic [7:0]  rx_byte;
  logic [15:0] count_inc;
  logic        short_frame;
  logic        residue_ok;

  // Bit-reverse the incoming byte: rx_data_i[0] lands on bit 7.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rev
    assign rx_data_rev[gi] = rx_data_i[7-gi];
  end

  assign rx_byte     = REFLECT_IN ? rx_data_rev : rx_data_i;
  assign count_inc   = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
  assign short_frame = ({1'b0, count_q} < MIN_LEN_W);
  assign residue_ok  = (crc_val_i == CRC_RESIDUE);

  assign crc_init_o      = CRC_SEED;
  assign crc_start_o     = start_q;
  assign crc_data_o      = data_q;
  assign frame_done_o    = done_q;
  assign frame_good_o    = good_q;
  assign frame_crc_err_o = crc_err_q;
  assign frame_len_err_o = len_err_q;
  assign frame_abort_o   = abort_flag_q;
  assign frame_len_o     = len_q;

  // State, engine strobe/data and status registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      count_q      <= 16'd0;
      abort_q      <= 1'b0;
      start_q      <= 1'b0;
      data_q       <= 8'd0;
      done_q       <= 1'b0;
      good_q       <= 1'b0;
      crc_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
      abort_flag_q <= 1'b0;
      len_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      abort_q      <= abort_d;
      start_q      <= start_d;
      data_q       <= data_d;
      done_q       <= done_d;
      good_q       <= good_d;
      crc_err_q    <= crc_err_d;
      len_err_q    <= len_err_d;
      abort_flag_q <= abort_flag_d;
      len_q        <= len_d;
    end
  end

  // Next-state, handshake and engine-control decode.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    abort_d      = abort_q;
    start_d      = 1'b0;
    data_d       = data_q;
    done_d       = 1'b0;
    good_d       = good_q;
    crc_err_d    = crc_err_q;
    len_err_d    = len_err_q;
    abort_flag_d = abort_flag_q;
    len_d        = len_q;
    rx_ready_o   = 1'b0;
    crc_load_o   = 1'b0;

    case (state_q)
      // REPORT behaves like IDLE so a new frame may start on the report cycle.
      ST_IDLE, ST_REPORT: begin
        rx_ready_o = 1'b1;
        state_d    = ST_IDLE;
        if (rx_valid_i && rx_sof_i) begin
          crc_load_o = 1'b1;
          start_d    = 1'b1;
          data_d     = rx_byte;
          count_d    = 16'd1;
          abort_d    = 1'b0;
          state_d    = rx_eof_i ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) begin
          if (rx_sof_i) begin
            // A new SOF kills the current frame; that SOF byte is discarded.
            abort_d = 1'b1;
            state_d = ST_FLUSH;
          end else begin
            start_d = 1'b1;
            data_d  = rx_byte;
            count_d = count_inc;
            if (rx_eof_i) begin
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        // Engine consumes the last byte this cycle.
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        done_d       = 1'b1;
        len_d        = count_q;
        abort_flag_d = abort_q;
        len_err_d    = short_frame;
        crc_err_d    = !abort_q && !residue_ok;
        good_d       = !abort_q && residue_ok && !short_frame;
        state_d      = ST_REPORT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
